// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction from a
// wait-state memory, holds it for the decoder and commits the next PC.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        exec_done,
    input  logic        stall,
    input  logic [1:0]  PCSrc,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] jr_target,
    output logic        fetch_timeout,
    output logic        pc_misalign
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [7:0]  r_cnt;
    logic        r_misalign;

    logic        w_capture;
    logic        w_commit;
    logic        w_timeout;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_next_pc;
    logic        w_jr_misalign;

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_REQ: begin
                if (imem_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = S_EXEC;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // A word arriving in the timeout cycle is still taken.
                if (imem_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = S_EXEC;
                end else if (r_cnt == TIMEOUT_CNT) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            S_EXEC: begin
                if (exec_done && !stall) begin
                    w_commit     = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_REQ;
        endcase
    end

    always_comb begin
        w_pc_plus4    = r_pc + 32'd4;
        w_br_off      = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
        w_jr_misalign = 1'b0;
        case (PCSrc)
            2'b01:   w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
            2'b10: begin
                w_next_pc     = {jr_target[31:2], 2'b00};
                w_jr_misalign = (jr_target[1:0] != 2'b00);
            end
            2'b00:   w_next_pc = (Branch && Zero) ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
            default: w_next_pc = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_inst     <= 32'd0;
            r_cnt      <= 8'd0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_inst <= imem_rdata;
            end
            if (w_commit) begin
                r_pc <= w_next_pc;
                if (w_jr_misalign) begin
                    r_misalign <= 1'b1;
                end
            end
            // Counter holds the number of WAIT cycles spent on the current attempt.
            case (r_state)
                S_REQ:   r_cnt <= imem_ready ? 8'd0 : 8'd1;
                S_WAIT:  r_cnt <= (imem_ready || w_timeout) ? 8'd0 : r_cnt + 8'd1;
                default: r_cnt <= 8'd0;
            endcase
        end
    end

    assign imem_req      = !reset && ((r_state == S_REQ) || (r_state == S_WAIT));
    assign imem_addr     = r_pc;
    assign inst_valid    = !reset && (r_state == S_EXEC);
    assign fetch_timeout = !reset && w_timeout;
    assign inst          = r_inst;
    assign OpCode        = r_inst[31:26];
    assign Funct         = r_inst[5:0];
    assign pc            = r_pc;
    assign pc_plus4      = w_pc_plus4;
    assign pc_misalign   = r_misalign;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic, all
// checked against a transaction-level fetch/execute reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        exec_done = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic        Branch = 1'b0;
    logic        Zero = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        fetch_timeout;
    logic        pc_misalign;

    pc_fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .OpCode(OpCode), .Funct(Funct),
        .pc(pc), .pc_plus4(pc_plus4),
        .exec_done(exec_done), .stall(stall), .PCSrc(PCSrc),
        .Branch(Branch), .Zero(Zero), .jr_target(jr_target),
        .fetch_timeout(fetch_timeout), .pc_misalign(pc_misalign)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;

    // Reference model: executing flag, PC, held instruction, consecutive miss count.
    logic        m_exec = 1'b0;
    logic [31:0] m_pc   = RST_PC;
    logic [31:0] m_inst = 32'd0;
    int          m_miss = 0;
    logic        m_mis  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_next_pc(input logic [1:0] src, input logic br,
                                                input logic z, input logic [31:0] jt);
        logic [31:0] seq;
        int          off;
        seq = m_pc + 32'd4;
        off = int'($signed(m_inst[15:0])) * 4;
        if (src == 2'b01) return (seq & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) << 2);
        if (src == 2'b10) return jt & 32'hFFFF_FFFC;
        if (src == 2'b00 && br && z) return seq + 32'(off);
        return seq;
    endfunction

    task automatic step(input logic rst, input logic rdy, input logic [31:0] rdata,
                        input logic done, input logic stl, input logic [1:0] src,
                        input logic br, input logic z, input logic [31:0] jt);
        logic exp_to;
        @(negedge clk);
        reset = rst; imem_ready = rdy; imem_rdata = rdata; exec_done = done;
        stall = stl; PCSrc = src; Branch = br; Zero = z; jr_target = jt;
        #1;
        if (fetch_timeout) n_pulse++;
        exp_to = !m_exec && !rdy && (m_miss == TO);
        if (rst) begin
            check("req_in_reset", 32'(imem_req), 32'd0);
            check("valid_in_reset", 32'(inst_valid), 32'd0);
            check("timeout_in_reset", 32'(fetch_timeout), 32'd0);
        end else begin
            check("imem_req", 32'(imem_req), 32'(!m_exec));
            if (!m_exec) check("imem_addr", imem_addr, m_pc);
            check("inst_valid", 32'(inst_valid), 32'(m_exec));
            check("pc", pc, m_pc);
            check("inst", inst, m_inst);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
            check("OpCode", 32'(OpCode), 32'(m_inst >> 26));
            check("Funct", 32'(Funct), m_inst & 32'h3F);
            check("fetch_timeout", 32'(fetch_timeout), 32'(exp_to));
            check("pc_misalign", 32'(pc_misalign), 32'(m_mis));
        end
        @(posedge clk);
        if (rst) begin
            m_exec = 1'b0; m_pc = RST_PC; m_inst = 32'd0; m_miss = 0; m_mis = 1'b0;
        end else if (!m_exec) begin
            if (rdy) begin
                m_inst = rdata; m_exec = 1'b1; m_miss = 0;
            end else if (exp_to) begin
                m_miss = 0;
            end else begin
                m_miss++;
            end
        end else if (done && !stl) begin
            if (src == 2'b10 && jt[1:0] != 2'b00) m_mis = 1'b1;
            m_pc   = ref_next_pc(src, br, z, jt);
            m_exec = 1'b0;
        end
    endtask

    // Fetch with zero waits and commit with the given control.
    task automatic run_inst(input logic [31:0] word, input logic [1:0] src,
                            input logic br, input logic z, input logic [31:0] jt);
        step(0, 1, word, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, src, br, z, jt);
    endtask

    initial begin
        int p0;
        logic [31:0] pc_hold;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 32'h1234_5678, 1, 0, 0, 0, 0, 0);

        // Back-to-back sequential instructions, two cycles each.
        for (int i = 0; i < 4; i++) run_inst(32'h0000_0020, 2'b00, 0, 0, 0);
        #1 check("seq_pc", pc, 32'h0000_0010);

        run_inst(32'h1000_FFFF, 2'b00, 1, 1, 0);
        #1 check("beq_taken", pc, 32'h0000_0010);
        run_inst(32'h1000_FFFF, 2'b00, 1, 0, 0);
        #1 check("beq_not_taken", pc, 32'h0000_0014);

        run_inst(32'h0000_0008, 2'b10, 0, 0, 32'hF000_0000);
        #1 check("jr_aligned_mis", 32'(pc_misalign), 32'd0);
        run_inst(32'h0800_0004, 2'b01, 0, 0, 0);
        #1 check("j_target", pc, 32'hF000_0010);
        run_inst(32'h0000_0008, 2'b10, 0, 0, 32'h0000_1236);
        #1 check("jr_target", pc, 32'h0000_1234);
        run_inst(32'h0000_0020, 2'b11, 0, 0, 0);
        run_inst(32'h0000_0020, 2'b00, 0, 0, 0);
        #1 check("misalign_sticky", 32'(pc_misalign), 32'd1);

        // Full timeout: REQ plus TO WAIT cycles without ready.
        pc_hold = pc;
        p0 = n_pulse;
        for (int i = 0; i <= TO; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("timeout_pulses", 32'(n_pulse - p0), 32'd1);
        #1 check("timeout_addr", imem_addr, pc_hold);
        // Ready arriving in the would-be timeout cycle wins.
        p0 = n_pulse;
        for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'hABCD_0001, 0, 0, 0, 0, 0, 0);
        check("late_ready_pulses", 32'(n_pulse - p0), 32'd0);
        #1 check("late_ready_inst", inst, 32'hABCD_0001);

        // Stall masks exec_done.
        for (int i = 0; i < 5; i++) step(0, 1, 32'hFFFF_FFFF, 1, 1, 2'b01, 0, 0, 0);
        #1 check("stall_pc", pc, pc_hold);
        check("stall_inst", inst, 32'hABCD_0001);
        step(0, 0, 0, 1, 0, 2'b00, 0, 0, 0);
        #1 check("stall_release", pc, pc_hold + 32'd4);

        // Reset in the middle of a WAIT at pc 0x40.
        step(0, 1, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 2'b10, 0, 0, 32'h0000_0040);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("pre_reset_pc", pc, 32'h0000_0040);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 check("post_reset_pc", pc, RST_PC);
        check("post_reset_valid", 32'(inst_valid), 32'd0);
        check("post_reset_mis", 32'(pc_misalign), 32'd0);
        p0 = n_pulse;
        for (int i = 0; i <= TO; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("post_reset_timeout", 32'(n_pulse - p0), 32'd1);

        // Randomized traffic with varying memory responsiveness.
        for (int seg = 0; seg < 12; seg++) begin
            int pct;
            pct = (seg % 3 == 0) ? 70 : ((seg % 3 == 1) ? 25 : 3);
            for (int c = 0; c < 250; c++) begin
                step($urandom_range(0, 299) == 0,
                     $urandom_range(0, 99) < pct,
                     $urandom,
                     1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0,
                     2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)),
                     $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
